// File: rtl/frequency_meter.sv
// frequency_meter: counts rising edges of sig_in over a gate window of
// GATE_CYCLES clk cycles and publishes the count, a saturation flag and a
// one-cycle valid pulse at the end of every window while en stays high.
// Optional feature macro: FREQ_METER_SYNC_EN adds a two-flop input
// synchronizer in front of the edge detector (default: single sample flop).
module frequency_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_out,
  output logic               valid,
  output logic               ovf,
  output logic               busy
);

  localparam int                 GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               sig_s;
  logic               sig_d;
  logic               sig_edge;
  logic [GATE_W-1:0]  gate_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic               sticky_ovf;
  logic               counting;
  logic               window_end;
  logic               cnt_at_max;

`ifdef FREQ_METER_SYNC_EN
  logic sig_meta;

  // Two-flop synchronizer: sig_in is asynchronous to clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_meta <= 1'b0;
      sig_s    <= 1'b0;
    end else begin
      sig_meta <= sig_in;
      sig_s    <= sig_meta;
    end
  end
`else
  // Single sample register: sig_in is already synchronous to clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_s <= 1'b0;
    end else begin
      sig_s <= sig_in;
    end
  end
`endif

  // Edge-detect history; loading it during ARM hides an already-high level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_d <= 1'b0;
    end else begin
      sig_d <= sig_s;
    end
  end

  assign sig_edge   = sig_s & ~sig_d;
  assign cnt_at_max = (edge_cnt == COUNT_MAX);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: dropping en anywhere in MEASURE aborts the window
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = ARM;
      ARM:     state_next = MEASURE;
      MEASURE: if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: counting only while measuring with en still high
  always_comb begin
    counting   = (state == MEASURE) && en;
    window_end = counting && (gate_cnt == GATE_LAST);
  end

  // Gate and edge counters; cleared outside MEASURE and at each window end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sticky_ovf <= 1'b0;
    end else if (!counting || window_end) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sticky_ovf <= 1'b0;
    end else begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      if (sig_edge) begin
        if (cnt_at_max) begin
          sticky_ovf <= 1'b1;
        end else begin
          edge_cnt <= edge_cnt + COUNT_W'(1);
        end
      end
    end
  end

  // Publish the result, including an edge on the window-end cycle itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freq_out <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= window_end;
      busy  <= (state != IDLE);
      if (window_end) begin
        freq_out <= (sig_edge && !cnt_at_max) ? edge_cnt + COUNT_W'(1) : edge_cnt;
        ovf      <= sticky_ovf | (sig_edge & cnt_at_max);
      end
    end
  end

endmodule

// File: tb/tb_frequency_meter.sv
// tb_frequency_meter: directed test of frequency_meter with two instances
// (COUNT_W 8 and 4) sharing all inputs, a window-level reference model and
// hand-computed literal expectations for each scenario.
module tb_frequency_meter;

  localparam int GATE = 100;
`ifdef FREQ_METER_SYNC_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       sig_in;
  logic [7:0] freq8;
  logic       valid8, ovf8, busy8;
  logic [3:0] freq4;
  logic       valid4, ovf4, busy4;

  int checks = 0;
  int errors = 0;
  int wavePh = 0;

  frequency_meter #(.GATE_CYCLES(GATE), .COUNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
    .freq_out(freq8), .valid(valid8), .ovf(ovf8), .busy(busy8)
  );

  frequency_meter #(.GATE_CYCLES(GATE), .COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
    .freq_out(freq4), .valid(valid4), .ovf(ovf4), .busy(busy4)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int satCount(input int cnt, input int maxVal);
    return (cnt > maxVal) ? maxVal : cnt;
  endfunction

  // Reference model: unbounded edge count per window, saturated on publish
  int  cycle = 0;
  int  armedAt = -1;
  int  edgeCount = 0;
  int  lastCount = 0;
  bit  expValid = 1'b0;
  bit  expBusy = 1'b0;
  bit  hist0 = 1'b0, hist1 = 1'b0, hist2 = 1'b0;

  always @(posedge clk) begin
    bit edgeSeen;
    bit wasActive;
    cycle++;
    if (reset) begin
      armedAt   = -1;
      edgeCount = 0;
      lastCount = 0;
      expValid  = 1'b0;
      expBusy   = 1'b0;
      hist0 = 1'b0; hist1 = 1'b0; hist2 = 1'b0;
    end else begin
      edgeSeen  = (DEPTH == 1) ? (hist0 && !hist1) : (hist1 && !hist2);
      wasActive = (armedAt >= 0);
      expValid  = 1'b0;
      if (armedAt < 0) begin
        if (en) armedAt = cycle;
      end else if (cycle == armedAt + 1) begin
        edgeCount = 0;
      end else if (!en) begin
        armedAt   = -1;
        edgeCount = 0;
      end else begin
        if (edgeSeen) edgeCount++;
        if ((cycle - armedAt - 2) % GATE == GATE - 1) begin
          lastCount = edgeCount;
          edgeCount = 0;
          expValid  = 1'b1;
        end
      end
      expBusy = wasActive;
      hist2 = hist1; hist1 = hist0; hist0 = sig_in;
    end
  end

  // Compare every cycle, one time unit after the active edge
  always @(posedge clk) begin
    #1;
    checkOutput("freq8", int'(freq8), satCount(lastCount, 255));
    checkOutput("ovf8", int'(ovf8), int'(lastCount > 255));
    checkOutput("valid8", int'(valid8), int'(expValid));
    checkOutput("busy8", int'(busy8), int'(expBusy));
    checkOutput("freq4", int'(freq4), satCount(lastCount, 15));
    checkOutput("ovf4", int'(ovf4), int'(lastCount > 15));
    checkOutput("valid4", int'(valid4), int'(expValid));
    checkOutput("busy4", int'(busy4), int'(expBusy));
  end

  task automatic waveStep(input int period, input bit level);
    if (period == 0) begin
      sig_in = level;
    end else begin
      if (wavePh >= period) wavePh = 0;
      sig_in = (wavePh < period / 2);
      wavePh = (wavePh + 1 >= period) ? 0 : wavePh + 1;
    end
  endtask

  task automatic applyStimulus(input bit enV, input int period, input bit level);
    @(negedge clk);
    en = enV;
    waveStep(period, level);
  endtask

  task automatic runWaveCycles(input int period, input bit level, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      waveStep(period, level);
    end
  endtask

  task automatic runWave(input int period, input bit level, input int nValid);
    int seen = 0;
    int budget = nValid * GATE + 300;
    while (seen < nValid && budget > 0) begin
      @(negedge clk);
      if (valid8) seen++;
      waveStep(period, level);
      budget--;
    end
    checkOutput("valid_timeout", seen, nValid);
  endtask

  task automatic countToValid(input int period, output int n);
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      waveStep(period, 1'b0);
      if (valid8) break;
    end
  endtask

  function automatic bit t6Level(input int i);
    return (i >= 10 && i < 13) || (i >= 30 && i < 33) ||
           (i >= 100 - DEPTH && i < 103 - DEPTH) ||
           (i >= 106 - DEPTH && i < 109 - DEPTH) ||
           (i >= 120 - DEPTH && i < 123 - DEPTH);
  endfunction

  initial begin
    int n;
    int got;
    int winFreq[2];
    reset  = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_freq", int'(freq8), 0);
    checkOutput("rst_ovf", int'(ovf8), 0);
    checkOutput("rst_valid", int'(valid8), 0);
    checkOutput("rst_busy", int'(busy8), 0);

    $display("[TB] period 10 square wave");
    applyStimulus(1'b1, 10, 1'b0);
    runWave(10, 1'b0, 2);
    checkOutput("p10_freq8", int'(freq8), 10);
    checkOutput("p10_freq4", int'(freq4), 10);
    checkOutput("p10_ovf8", int'(ovf8), 0);
    checkOutput("p10_busy", int'(busy8), 1);

    $display("[TB] abort at cycle 50");
    runWaveCycles(10, 1'b0, 49);
    applyStimulus(1'b0, 10, 1'b0);
    runWaveCycles(10, 1'b0, 2);
    checkOutput("abort_busy", int'(busy8), 0);
    checkOutput("abort_freq", int'(freq8), 10);
    checkOutput("abort_valid", int'(valid8), 0);
    applyStimulus(1'b1, 10, 1'b0);
    countToValid(10, n);
    checkOutput("rearm_latency", n, 102);
    checkOutput("rearm_freq", int'(freq8), 10);

    $display("[TB] level high before enable");
    applyStimulus(1'b0, 0, 1'b1);
    runWaveCycles(0, 1'b1, 5);
    applyStimulus(1'b1, 0, 1'b1);
    runWave(0, 1'b1, 1);
    checkOutput("high_freq", int'(freq8), 0);
    checkOutput("high_ovf", int'(ovf8), 0);
    runWave(25, 1'b0, 2);
    checkOutput("p25_freq", int'(freq8), 4);

    $display("[TB] saturation");
    runWave(4, 1'b0, 2);
    checkOutput("p4_freq4", int'(freq4), 15);
    checkOutput("p4_ovf4", int'(ovf4), 1);
    checkOutput("p4_freq8", int'(freq8), 25);
    checkOutput("p4_ovf8", int'(ovf8), 0);
    runWave(10, 1'b0, 2);
    checkOutput("recover_freq4", int'(freq4), 10);
    checkOutput("recover_ovf4", int'(ovf4), 0);

    $display("[TB] reset mid-window");
    runWaveCycles(10, 1'b0, 69);
    @(negedge clk);
    reset = 1'b1;
    waveStep(10, 1'b0);
    #1;
    checkOutput("mid_rst_freq", int'(freq8), 0);
    checkOutput("mid_rst_ovf", int'(ovf4), 0);
    checkOutput("mid_rst_valid", int'(valid8), 0);
    checkOutput("mid_rst_busy", int'(busy8), 0);
    runWaveCycles(10, 1'b0, 3);
    @(negedge clk);
    reset = 1'b0;
    waveStep(10, 1'b0);
    countToValid(10, n);
    checkOutput("post_rst_latency", n, 102);

    $display("[TB] edge on window-end cycle");
    runWave(0, 1'b0, 2);
    checkOutput("quiet_freq", int'(freq8), 0);
    sig_in = 1'b0;
    got = 0;
    winFreq[0] = -1;
    winFreq[1] = -1;
    for (int i = 2; i <= 215 && got < 2; i++) begin
      @(negedge clk);
      if (valid8) begin
        winFreq[got] = int'(freq8);
        got++;
      end
      sig_in = t6Level(i);
    end
    checkOutput("boundary_windows", got, 2);
    checkOutput("boundary_winA", winFreq[0], 3);
    checkOutput("boundary_winB", winFreq[1], 2);
    checkOutput("boundary_sum", winFreq[0] + winFreq[1], 5);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
